// File: rtl/instr_line_fill_if.sv
// Fetch-miss, instruction-store and line-return signals of the instruction fill engine.
// master = fill engine side, slave = cpu/store side.
interface instr_line_fill_if;
    logic         cacheMissFetch;
    logic [31:0]  instrAddr;
    logic         memReq;
    logic [31:0]  memAddr;
    logic [31:0]  memRdata;
    logic         memRvalid;
    logic [511:0] mcInstrIn;
    logic         mcInstrValid;
    logic         fetchFault;
    logic         busy;

    modport master (
        input  cacheMissFetch, instrAddr, memRdata, memRvalid,
        output memReq, memAddr, mcInstrIn, mcInstrValid, fetchFault, busy
    );

    modport slave (
        output cacheMissFetch, instrAddr, memRdata, memRvalid,
        input  memReq, memAddr, mcInstrIn, mcInstrValid, fetchFault, busy
    );
endinterface

// File: rtl/instr_line_fill.sv
// Instruction line fill: reads 16 words serially, one read outstanding, returns a 512-bit line.
// Latency 34 cycles miss-to-mcInstrValid with 1-cycle memory; the store paces the fill via memRvalid.
module instr_line_fill #(
    parameter int INSTR_WORDS    = 2048,
    parameter int WORDS_PER_LINE = 16
) (
    input  logic               clk,
    input  logic               rst,
    instr_line_fill_if.master  bus
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE,
        ST_FAULT,
        ST_HOLD
    } state_t;

    localparam logic [31:0] MAX_BASE = 32'(INSTR_WORDS - WORDS_PER_LINE);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [31:0]    r_base;
    logic [3:0]     r_cnt;
    logic [511:0]   r_shadow;
    logic [511:0]   r_line;
    logic           r_line_vld;
    logic [31:0]    w_base;
    logic           w_base_oob;
    logic           w_mem_req;
    logic           w_fault;
    logic           w_busy;

    assign w_base     = bus.instrAddr & ~32'h0000_000F;
    assign w_base_oob = (w_base > MAX_BASE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mem_req   = 1'b0;
        w_fault     = 1'b0;
        w_busy      = 1'b1;
        unique case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (bus.cacheMissFetch) begin
                    w_state_nxt = w_base_oob ? ST_FAULT : ST_REQ;
                end
            end
            ST_REQ: begin
                w_mem_req   = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.memRvalid) begin
                    w_state_nxt = (r_cnt == 4'd15) ? ST_DONE : ST_REQ;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            ST_FAULT: begin
                w_fault     = 1'b1;
                w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                // Wait for the cpu to drop the miss so one bad address faults only once.
                if (!bus.cacheMissFetch) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_base     <= '0;
            r_cnt      <= '0;
            r_shadow   <= '0;
            r_line     <= '0;
            r_line_vld <= 1'b0;
        end else begin
            r_line_vld <= (r_state == ST_DONE);
            if (r_state == ST_IDLE && bus.cacheMissFetch && !w_base_oob) begin
                r_base <= w_base;
                r_cnt  <= '0;
            end
            if (r_state == ST_WAIT && bus.memRvalid) begin
                r_shadow[{r_cnt, 5'd0} +: 32] <= bus.memRdata;
                if (r_cnt != 4'd15) begin
                    r_cnt <= r_cnt + 4'd1;
                end
            end
            // The visible line moves only here, so a partial fill never leaks out.
            if (r_state == ST_DONE) begin
                r_line <= r_shadow;
            end
        end
    end

    assign bus.memReq       = w_mem_req;
    assign bus.memAddr      = r_base + {28'd0, r_cnt};
    assign bus.mcInstrIn    = r_line;
    assign bus.mcInstrValid = r_line_vld;
    assign bus.fetchFault   = w_fault;
    assign bus.busy         = w_busy;
endmodule

// File: tb/tb_instr_line_fill.sv
// Directed bench for instr_line_fill: table-driven misses plus reset and back-to-back sequences.
module tb_instr_line_fill;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_line_fill_if bus ();

    instr_line_fill #(
        .INSTR_WORDS    (2048),
        .WORDS_PER_LINE (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          lat_max;
        logic        exp_fault;
        logic [31:0] exp_base;
        int          exp_lat;
        string       name;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic        m_rvalid = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        stray = 1'b0;
    int          mem_lat_max = 1;
    bit          mem_en = 1'b1;
    int          pend = 0;
    logic [31:0] pend_addr = '0;
    int          dbl_req = 0;
    int          n_rvalid = 0;
    int          n_valid = 0;
    int          n_fault = 0;
    int          line_jump = 0;
    logic [511:0] prev_line = '0;
    logic [31:0] addr_q[$];

    assign bus.memRvalid = m_rvalid | stray;
    assign bus.memRdata  = stray ? 32'hDEAD_BEEF : m_rdata;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b want %0b", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chkl(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Word-serial instruction store: word at address a holds 32'h1000_0000 + a.
    initial begin : mem_model
        bit was_pending;
        forever begin
            @(negedge clk);
            m_rvalid    = 1'b0;
            was_pending = (pend != 0);
            if (!mem_en) begin
                pend = 0;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    m_rvalid = 1'b1;
                    m_rdata  = 32'h1000_0000 + pend_addr;
                    n_rvalid++;
                end
            end
            if (bus.memReq === 1'b1) begin
                addr_q.push_back(bus.memAddr);
                if (was_pending) dbl_req++;
                pend      = (mem_lat_max <= 1) ? 1 : int'($urandom_range(mem_lat_max, 1));
                pend_addr = bus.memAddr;
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (bus.mcInstrValid === 1'b1) n_valid++;
            if (bus.fetchFault === 1'b1) n_fault++;
            if (bus.mcInstrIn !== prev_line && bus.mcInstrValid !== 1'b1 && rst !== 1'b1) line_jump++;
            prev_line = bus.mcInstrIn;
        end
    end

    function automatic logic [511:0] line_of(input logic [31:0] base);
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[32*i +: 32] = 32'h1000_0000 + base + 32'(i);
        return l;
    endfunction

    task automatic wait_valid(input string nm, output int n);
        int got;
        got = 0;
        n   = 0;
        while (got == 0 && n < 400) begin
            tick();
            n++;
            if (bus.mcInstrValid === 1'b1) got = 1;
        end
        chk32({nm, "_done"}, 32'(got), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        logic [511:0] line_before;
        int           n;
        int           bad;
        mem_lat_max = v.lat_max;
        addr_q.delete();
        n_valid = 0;
        n_fault = 0;
        line_before = bus.mcInstrIn;
        bus.instrAddr      = v.addr;
        bus.cacheMissFetch = 1'b1;
        if (!v.exp_fault) begin
            wait_valid(v.name, n);
            if (v.exp_lat > 0) chk32({v.name, "_lat"}, 32'(n), 32'(v.exp_lat));
            chkl({v.name, "_line"}, bus.mcInstrIn, line_of(v.exp_base));
            chk32({v.name, "_nreq"}, 32'(addr_q.size()), 32'd16);
            bad = 0;
            for (int i = 0; i < addr_q.size() && i < 16; i++)
                if (addr_q[i] !== v.exp_base + 32'(i)) bad++;
            chk32({v.name, "_addr_seq"}, 32'(bad), 32'd0);
            bus.cacheMissFetch = 1'b0;
            tick();
            tick();
            chk32({v.name, "_valid_pulses"}, 32'(n_valid), 32'd1);
            chk1({v.name, "_idle"}, bus.busy, 1'b0);
        end else begin
            repeat (10) tick();
            chk1({v.name, "_busy_held"}, bus.busy, 1'b1);
            chk32({v.name, "_fault_pulses"}, 32'(n_fault), 32'd1);
            chk32({v.name, "_no_req"}, 32'(addr_q.size()), 32'd0);
            chk32({v.name, "_no_valid"}, 32'(n_valid), 32'd0);
            chkl({v.name, "_line_kept"}, bus.mcInstrIn, line_before);
            bus.cacheMissFetch = 1'b0;
            tick();
            tick();
            chk1({v.name, "_busy_drop"}, bus.busy, 1'b0);
        end
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t vecs[7];
        vec_t post;
        int   n;
        vecs[0] = '{32'h0000_0000, 1, 1'b0, 32'h0000_0000, 34, "fill_base0"};
        vecs[1] = '{32'h0000_0023, 1, 1'b0, 32'h0000_0020, 34, "unaligned"};
        vecs[2] = '{32'h0000_07F5, 1, 1'b0, 32'h0000_07F0, 34, "top_line"};
        vecs[3] = '{32'h0000_0800, 1, 1'b1, 32'h0000_0000, 0,  "fault_800"};
        vecs[4] = '{32'h0000_013A, 8, 1'b0, 32'h0000_0130, 0,  "varlat_130"};
        vecs[5] = '{32'hFFFF_FFFF, 1, 1'b1, 32'h0000_0000, 0,  "fault_max"};
        vecs[6] = '{32'h0000_07EF, 8, 1'b0, 32'h0000_07E0, 0,  "varlat_7e0"};

        rst = 1'b1;
        bus.cacheMissFetch = 1'b0;
        bus.instrAddr      = '0;
        repeat (3) tick();
        chk1("rst_memReq", bus.memReq, 1'b0);
        chk32("rst_memAddr", bus.memAddr, 32'h0);
        chkl("rst_line", bus.mcInstrIn, 512'h0);
        chk1("rst_valid", bus.mcInstrValid, 1'b0);
        chk1("rst_fault", bus.fetchFault, 1'b0);
        chk1("rst_busy", bus.busy, 1'b0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Reset in the middle of a fill, then a stray read return.
        mem_lat_max = 1;
        n_rvalid = 0;
        bus.instrAddr      = 32'h0000_0100;
        bus.cacheMissFetch = 1'b1;
        n = 0;
        while (n_rvalid < 5 && n < 200) begin
            tick();
            n++;
        end
        chk32("midrst_reach5", 32'(n_rvalid), 32'd5);
        rst = 1'b1;
        mem_en = 1'b0;
        bus.cacheMissFetch = 1'b0;
        n_valid = 0;
        repeat (2) tick();
        chk1("midrst_memReq", bus.memReq, 1'b0);
        chk32("midrst_memAddr", bus.memAddr, 32'h0);
        chkl("midrst_line", bus.mcInstrIn, 512'h0);
        chk1("midrst_busy", bus.busy, 1'b0);
        rst = 1'b0;
        tick();
        stray = 1'b1;
        tick();
        stray = 1'b0;
        chk1("stray_busy", bus.busy, 1'b0);
        chk1("stray_memReq", bus.memReq, 1'b0);
        repeat (3) tick();
        chk32("stray_no_valid", 32'(n_valid), 32'd0);
        chk1("stray_still_idle", bus.busy, 1'b0);
        mem_en = 1'b1;
        post = '{32'h0000_0040, 1, 1'b0, 32'h0000_0040, 34, "post_rst"};
        run_vec(post);

        // Back-to-back: miss held through DONE, address moved mid-fill.
        mem_lat_max = 1;
        n_valid = 0;
        bus.instrAddr      = 32'h0000_0000;
        bus.cacheMissFetch = 1'b1;
        repeat (5) tick();
        bus.instrAddr = 32'h0000_0010;
        wait_valid("b2b_first", n);
        chkl("b2b_first_line", bus.mcInstrIn, line_of(32'h0));
        tick();
        chk1("b2b_req_next", bus.memReq, 1'b1);
        chk32("b2b_addr_next", bus.memAddr, 32'h0000_0010);
        bus.cacheMissFetch = 1'b0;
        wait_valid("b2b_second", n);
        chkl("b2b_second_line", bus.mcInstrIn, line_line_guard(32'h0000_0010));
        tick();
        tick();
        chk32("b2b_valid_pulses", 32'(n_valid), 32'd2);
        chk1("b2b_idle", bus.busy, 1'b0);

        chk32("one_outstanding", 32'(dbl_req), 32'd0);
        chk32("line_stable", 32'(line_jump), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    function automatic logic [511:0] line_line_guard(input logic [31:0] base);
        return line_of(base);
    endfunction
endmodule
